// File: rtl/datamem_pipe_if.sv
// -----------------------------------------------------------------------------
// datamem_pipe_if
//
// Groups the request channel, the response channel and the error counter of
// the pipelined data memory.
//
//   master modport : CPU memory stage side (drives requests, consumes responses)
//   slave  modport : memory side (datamem_pipe)
//
// Request channel  : req_valid/req_ready handshake, req_write, req_addr,
//                    req_size (log2 bytes), req_wdata, req_signed
// Response channel : resp_valid/resp_ready handshake, resp_rdata, resp_err
// Status           : err_count (saturating count of rejected requests)
// -----------------------------------------------------------------------------
interface datamem_pipe_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_wdata;
    logic              req_signed;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic [15:0]       err_count;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata, req_signed,
        output resp_ready,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  err_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata, req_signed,
        input  resp_ready,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output err_count
    );
endinterface

// File: rtl/datamem_pipe.sv
// -----------------------------------------------------------------------------
// datamem_pipe
//
// Pipelined, byte-addressed, little-endian data memory. Aligned accesses of
// 1/2/4/8 bytes arrive on a valid/ready request channel; every accepted
// request (loads, stores and rejected accesses alike) yields exactly one
// response on a valid/ready response channel, in order.
//
// Timing: a request accepted at edge E is registered into stage 0 at E and
// walks through LAT register stages, so it is presented on resp_* during the
// cycle that ends at edge E+LAT. Storage is read and written at the accept
// edge, so a load accepted right after a store sees the stored bytes.
//
// Backpressure: when the output stage holds a response that is not being
// taken, every stage holds and req_ready drops.
//
// Illegal accesses (misaligned, past the end of storage, or wider than the
// data bus) do not touch storage; they return resp_err=1 with zero data and
// bump a saturating 16-bit error counter at accept.
//
// Ports:
//   clk    : clock, all state on posedge
//   reset  : asynchronous, active-high reset (storage is not reset)
//   bus    : datamem_pipe_if.slave (request/response channels, err_count)
//
// Parameters:
//   MEM_BYTES : storage size in bytes (power of 2, > 8)
//   DATA_W    : data width, 32 or 64
//   ADDR_W    : request address width
//   LAT       : accept-to-response latency in cycles, 1 or 2
//
// Build option:
//   DATAMEM_SIGNEXT_EN : when defined, loads with req_signed=1 sign-extend
//                        from the top bit of the transferred bytes; when not
//                        defined, req_signed is ignored and loads zero-extend.
// -----------------------------------------------------------------------------
module datamem_pipe #(
    parameter int MEM_BYTES = 1024,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int LAT       = 1
) (
    input  logic          clk,
    input  logic          reset,
    datamem_pipe_if.slave bus
);

    localparam int NB = DATA_W / 8;          // byte lanes on the data bus
    localparam int AW = $clog2(MEM_BYTES);   // storage index width

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [7:0] mem_q [MEM_BYTES];

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic              stall;
    logic              req_ready;
    logic              accept;
    logic [3:0]        size_bytes;
    logic [2:0]        align_mask;
    logic [ADDR_W:0]   end_addr;
    logic              misaligned;
    logic              out_of_range;
    logic              oversize;
    logic              legal;
    logic              wr_en;
    logic [AW-1:0]     base;
    logic [DATA_W-1:0] load_data;

    // -------------------------------------------------------------------------
    // Pipeline state: stage LAT-1 drives the response channel
    // -------------------------------------------------------------------------
    logic [LAT-1:0]             stage_valid_q, stage_valid_d;
    logic [LAT-1:0]             stage_err_q,   stage_err_d;
    logic [LAT-1:0][DATA_W-1:0] stage_rdata_q, stage_rdata_d;
    logic [15:0]                err_count_q,   err_count_d;

    // The output stage is full and the consumer is not taking it: freeze.
    assign stall     = stage_valid_q[LAT-1] && !bus.resp_ready;
    assign req_ready = !reset && !stall;
    assign accept    = bus.req_valid && req_ready;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path through the block leaves a value unassigned
    // (which would otherwise infer a latch).
    always_comb begin
        size_bytes = 4'd1 << bus.req_size;
        align_mask = 3'(size_bytes - 4'd1);

        // Low address bits must be zero for the transfer size.
        misaligned = |(bus.req_addr[2:0] & align_mask);

        // One extra bit of headroom so a huge address cannot wrap past zero
        // and look in range.
        end_addr     = {1'b0, bus.req_addr} + {{(ADDR_W - 3){1'b0}}, size_bytes};
        out_of_range = end_addr > (ADDR_W + 1)'(MEM_BYTES);

        oversize = int'(size_bytes) > NB;

        legal = !misaligned && !out_of_range && !oversize;
        wr_en = accept && legal && bus.req_write;
        base  = bus.req_addr[AW-1:0];
    end

    // -------------------------------------------------------------------------
    // Load data: little-endian gather of the addressed bytes; lanes at or
    // above the transfer size are zero, or copies of the sign bit when signed
    // loads are built in and requested.
    // -------------------------------------------------------------------------
`ifdef DATAMEM_SIGNEXT_EN
    logic sign_bit;

    always_comb begin
        load_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (4'(i) < size_bytes) begin
                load_data[8*i +: 8] = mem_q[base + AW'(i)];
            end
        end

        // Top bit of the transferred bytes; the 8-byte case only matters on a
        // 64-bit bus (it is rejected as oversize on a 32-bit one).
        case (bus.req_size)
            2'd0:    sign_bit = load_data[7];
            2'd1:    sign_bit = load_data[15];
            2'd2:    sign_bit = load_data[31];
            default: sign_bit = load_data[DATA_W-1];
        endcase
        sign_bit = sign_bit && bus.req_signed;

        for (int i = 0; i < NB; i++) begin
            if (4'(i) >= size_bytes) begin
                load_data[8*i +: 8] = {8{sign_bit}};
            end
        end
    end
`else
    // Signed loads are not built in; the request bit is deliberately dropped.
    logic unused_req_signed;
    assign unused_req_signed = bus.req_signed;

    always_comb begin
        load_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (4'(i) < size_bytes) begin
                load_data[8*i +: 8] = mem_q[base + AW'(i)];
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Pipeline and error counter next state
    // -------------------------------------------------------------------------
    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_err_d   = stage_err_q;
        stage_rdata_d = stage_rdata_q;
        err_count_d   = err_count_q;

        if (!stall) begin
            // Stage 0 captures the accepted request; an idle cycle inserts a
            // bubble with cleared payload so stale data never reaches resp_*.
            stage_valid_d[0] = accept;
            stage_err_d[0]   = accept && !legal;
            stage_rdata_d[0] = (accept && legal && !bus.req_write) ? load_data : '0;

            for (int k = 1; k < LAT; k++) begin
                stage_valid_d[k] = stage_valid_q[k-1];
                stage_err_d[k]   = stage_err_q[k-1];
                stage_rdata_d[k] = stage_rdata_q[k-1];
            end
        end

        if (accept && !legal && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // NOTE: sequential blocks use non-blocking '<=' so every flop samples the
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid_q <= '0;
            stage_err_q   <= '0;
            stage_rdata_q <= '0;
            err_count_q   <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_err_q   <= stage_err_d;
            stage_rdata_q <= stage_rdata_d;
            err_count_q   <= err_count_d;
        end
    end

    // NOTE: the storage array has no reset: clearing it would need a write
    // port per byte, and stores accepted before a reset must survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (4'(i) < size_bytes) begin
                    mem_q[base + AW'(i)] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = stage_valid_q[LAT-1];
    assign bus.resp_err   = stage_err_q[LAT-1];
    assign bus.resp_rdata = stage_rdata_q[LAT-1];
    assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_datamem_pipe.sv
// -----------------------------------------------------------------------------
// tb_datamem_pipe
//
// Directed bench for datamem_pipe built with a two-stage pipeline, 1 KiB of
// storage and a 64-bit bus. Each scenario task drives its own stimulus and
// compares the response channel against hand-computed values.
// -----------------------------------------------------------------------------
module tb_datamem_pipe;

    localparam int MEM_BYTES = 1024;
    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 64;
    localparam int LAT       = 2;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    datamem_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    datamem_pipe #(
        .MEM_BYTES (MEM_BYTES),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .LAT       (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // One request with resp_ready high: waits for acceptance, confirms the
    // response is absent before edge E+LAT and present with the expected
    // payload during the cycle ending at E+LAT.
    task automatic access(input logic wr, input logic [63:0] addr,
                          input logic [1:0] size, input logic [63:0] wdata,
                          input logic sgn, input logic [63:0] exp_rdata,
                          input logic exp_err, input string name);
        int tries = 0;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_size   = size;
        bus.req_wdata  = wdata;
        bus.req_signed = sgn;
        #1;
        while (!bus.req_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        n_checks++;
        if (tries >= 50) begin
            n_fail++;
            $display("FAIL %s accept: req_ready never rose within 50 cycles", name);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (LAT - 1) begin
            @(negedge clk);
            n_checks++;
            if (bus.resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s early: resp_valid=%b expected 0", name, bus.resp_valid);
            end
            @(posedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s valid: resp_valid=%b expected 1", name, bus.resp_valid);
        end
        n_checks++;
        if (bus.resp_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got %h expected %h", name, bus.resp_rdata, exp_rdata);
        end
        n_checks++;
        if (bus.resp_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b expected %b", name, bus.resp_err, exp_err);
        end
    endtask

    task automatic test_reset;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_size   = 2'd0;
        bus.req_wdata  = '0;
        bus.req_signed = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset resp_valid: got %b expected 0", bus.resp_valid);
        end
        n_checks++;
        if (bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset resp_err: got %b expected 0", bus.resp_err);
        end
        n_checks++;
        if (bus.resp_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset resp_rdata: got %h expected 0", bus.resp_rdata);
        end
        n_checks++;
        if (bus.err_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset err_count: got %h expected 0", bus.err_count);
        end
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset req_ready: got %b expected 0", bus.req_ready);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post-reset req_ready: got %b expected 1", bus.req_ready);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle resp_valid: got %b expected 0", bus.resp_valid);
        end
    endtask

    task automatic test_store_load;
        access(1'b1, 64'd16, 2'd3, 64'h8877665544332211, 1'b0, 64'h0, 1'b0, "st16_d");
        access(1'b0, 64'd16, 2'd0, 64'h0, 1'b0, 64'h11, 1'b0, "ld16_b");
        access(1'b0, 64'd18, 2'd1, 64'h0, 1'b0, 64'h4433, 1'b0, "ld18_h");
        access(1'b0, 64'd16, 2'd3, 64'h0, 1'b0, 64'h8877665544332211, 1'b0, "ld16_d");
        access(1'b0, 64'd20, 2'd2, 64'h0, 1'b0, 64'h88776655, 1'b0, "ld20_w");
        access(1'b0, 64'd23, 2'd0, 64'h0, 1'b0, 64'h88, 1'b0, "ld23_b");
        // Partial store must leave neighbours alone.
        access(1'b1, 64'd18, 2'd1, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 64'h0, 1'b0, "st18_h");
        access(1'b0, 64'd16, 2'd3, 64'h0, 1'b0, 64'h88776655BEEF2211, 1'b0, "ld16_d2");
    endtask

    task automatic test_errors;
        access(1'b1, 64'd1016, 2'd3, 64'h0123456789ABCDEF, 1'b0, 64'h0, 1'b0, "st1016_d");
        access(1'b0, 64'd6, 2'd2, 64'h0, 1'b0, 64'h0, 1'b1, "ld6_misaligned");
        n_checks++;
        if (bus.err_count !== 16'd1) begin
            n_fail++;
            $display("FAIL err_count after misaligned: got %0d expected 1", bus.err_count);
        end
        access(1'b1, 64'd1020, 2'd3, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0, 64'h0, 1'b1, "st1020_oor");
        n_checks++;
        if (bus.err_count !== 16'd2) begin
            n_fail++;
            $display("FAIL err_count after oor store: got %0d expected 2", bus.err_count);
        end
        access(1'b0, 64'd1016, 2'd3, 64'h0, 1'b0, 64'h0123456789ABCDEF, 1'b0, "ld1016_unchanged");
        access(1'b0, 64'd1024, 2'd0, 64'h0, 1'b0, 64'h0, 1'b1, "ld1024_oor");
        // Address near the top of the 64-bit space must not wrap into range.
        access(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 64'h1, 1'b0, 64'h0, 1'b1, "st_wrap");
        access(1'b0, 64'd17, 2'd1, 64'h0, 1'b0, 64'h0, 1'b1, "ld17_misaligned");
        n_checks++;
        if (bus.err_count !== 16'd5) begin
            n_fail++;
            $display("FAIL err_count after 5 errors: got %0d expected 5", bus.err_count);
        end
        // Last legal byte of storage.
        access(1'b1, 64'd1023, 2'd0, 64'h5A, 1'b0, 64'h0, 1'b0, "st1023_b");
        access(1'b0, 64'd1023, 2'd0, 64'h0, 1'b0, 64'h5A, 1'b0, "ld1023_b");
        access(1'b0, 64'd1016, 2'd3, 64'h0, 1'b0, 64'h5A23456789ABCDEF, 1'b0, "ld1016_merged");
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_data [4];
        logic [63:0] addrs    [4];
        int          got;
        for (int j = 0; j < 4; j++) begin
            addrs[j]    = 64'd32 + 64'(8 * j);
            exp_data[j] = 64'hA0A0_0000_0000_0000 | 64'((j + 1) * 32'h0101_0101);
            access(1'b1, addrs[j], 2'd3, exp_data[j], 1'b0, 64'h0, 1'b0, "st_b2b");
        end
        // Let the last store response drain before withholding resp_ready.
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        got = 0;
        fork
            begin : driver
                for (int j = 0; j < 4; j++) begin
                    int tries;
                    tries          = 0;
                    bus.req_valid  = 1'b1;
                    bus.req_write  = 1'b0;
                    bus.req_addr   = addrs[j];
                    bus.req_size   = 2'd3;
                    bus.req_signed = 1'b0;
                    @(negedge clk);
                    while (!bus.req_ready && tries < 40) begin
                        @(negedge clk);
                        tries++;
                    end
                    if (tries >= 40) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL b2b accept: load %0d not accepted within 40 cycles", j);
                        break;
                    end
                    @(posedge clk);
                    #1;
                end
                bus.req_valid = 1'b0;
            end
            begin : monitor
                repeat (40) begin
                    @(negedge clk);
                    if (bus.resp_valid && bus.resp_ready) begin
                        if (got < 4) begin
                            n_checks++;
                            if (bus.resp_rdata !== exp_data[got] || bus.resp_err !== 1'b0) begin
                                n_fail++;
                                $display("FAIL b2b order: response %0d got %h err %b expected %h err 0",
                                         got, bus.resp_rdata, bus.resp_err, exp_data[got]);
                            end
                        end
                        got++;
                    end
                end
            end
            begin : staller
                int tries;
                tries = 0;
                @(negedge clk);
                while (!bus.resp_valid && tries < 20) begin
                    @(negedge clk);
                    tries++;
                end
                if (tries >= 20) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b2b stall: no response within 20 cycles");
                end else begin
                    for (int c = 0; c < 3; c++) begin
                        if (c > 0) @(negedge clk);
                        n_checks++;
                        if (bus.req_ready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL b2b stall req_ready: cycle %0d got %b expected 0", c, bus.req_ready);
                        end
                        n_checks++;
                        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp_data[0] || bus.resp_err !== 1'b0) begin
                            n_fail++;
                            $display("FAIL b2b stall hold: cycle %0d valid %b data %h err %b expected 1 %h 0",
                                     c, bus.resp_valid, bus.resp_rdata, bus.resp_err, exp_data[0]);
                        end
                    end
                end
                @(posedge clk);
                #1 bus.resp_ready = 1'b1;
            end
        join
        n_checks++;
        if (got !== 4) begin
            n_fail++;
            $display("FAIL b2b count: got %0d responses expected 4", got);
        end
    endtask

    task automatic test_signext;
`ifdef DATAMEM_SIGNEXT_EN
        localparam logic [63:0] EXP_B_SIGNED = 64'hFFFF_FFFF_FFFF_FF80;
        localparam logic [63:0] EXP_H_SIGNED = 64'hFFFF_FFFF_FFFF_8001;
`else
        localparam logic [63:0] EXP_B_SIGNED = 64'h80;
        localparam logic [63:0] EXP_H_SIGNED = 64'h8001;
`endif
        access(1'b1, 64'd5, 2'd0, 64'h80, 1'b0, 64'h0, 1'b0, "st5_b");
        access(1'b0, 64'd5, 2'd0, 64'h0, 1'b1, EXP_B_SIGNED, 1'b0, "ld5_b_signed");
        access(1'b0, 64'd5, 2'd0, 64'h0, 1'b0, 64'h80, 1'b0, "ld5_b_unsigned");
        access(1'b1, 64'd6, 2'd1, 64'h8001, 1'b0, 64'h0, 1'b0, "st6_h");
        access(1'b0, 64'd6, 2'd1, 64'h0, 1'b1, EXP_H_SIGNED, 1'b0, "ld6_h_signed");
        access(1'b1, 64'd8, 2'd2, 64'h7FFF_FFFF, 1'b0, 64'h0, 1'b0, "st8_w");
        access(1'b0, 64'd8, 2'd2, 64'h0, 1'b1, 64'h7FFF_FFFF, 1'b0, "ld8_w_positive");
    endtask

    task automatic test_reset_inflight;
        int seen;
        access(1'b1, 64'd24, 2'd3, 64'hCAFE_F00D_1234_5678, 1'b0, 64'h0, 1'b0, "st24_d");
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_addr   = 64'd24;
        bus.req_size   = 2'd3;
        bus.req_signed = 1'b0;
        @(posedge clk);
        #1 bus.req_addr = 64'd28;
        bus.req_size = 2'd2;
        @(posedge clk);
        #1 reset = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL inflight reset: resp_valid %b req_ready %b expected 0 0",
                     bus.resp_valid, bus.req_ready);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL inflight ghost: %0d cycles with resp_valid expected 0", seen);
        end
        n_checks++;
        if (bus.err_count !== 16'h0) begin
            n_fail++;
            $display("FAIL inflight err_count: got %0d expected 0", bus.err_count);
        end
        access(1'b0, 64'd24, 2'd3, 64'h0, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b0, "ld24_preserved");
        access(1'b0, 64'd16, 2'd3, 64'h0, 1'b0, 64'h88776655BEEF2211, 1'b0, "ld16_preserved");
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_back_to_back();
        test_signext();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datamem_pipe.md
Name: datamem_pipe

Overview:
Parametrised, pipelined successor to the single-cycle data memory. Byte-addressed, little-endian, aligned accesses of 1/2/4/8 bytes over a valid/ready request channel and a valid/ready response channel, with configurable depth, data width and read latency. Illegal accesses are rejected with an error response instead of a simulation-only assert. Sits between the CPU memory stage and storage.

Parameters:
MEM_BYTES, 1024, storage size in bytes; power of 2, >8.
DATA_W, 64, data width in bits; 32 or 64.
ADDR_W, 64, request address width.
LAT, 1, request-accept to response-valid latency in cycles; 1 or 2.

Ports:
clk  in  1  clock, all state on posedge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when req_valid && req_ready at posedge.
req_write  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address.
req_size  in  2  log2 of transfer bytes: 0=1, 1=2, 2=4, 3=8.
req_wdata  in  DATA_W  store data, bytes [0..size-1] used, little-endian.
req_signed  in  1  load sign-extension request; used only with feature enabled.
resp_valid  out  1  response present.
resp_ready  in  1  response consumed when resp_valid && resp_ready at posedge.
resp_rdata  out  DATA_W  load data; zero for stores and errors.
resp_err  out  1  access was rejected.
err_count  out  16  saturating count of rejected requests.

Behaviour:
- Reset (async, active-high): resp_valid=0, resp_err=0, resp_rdata=0, err_count=0, all pipeline stages invalid; req_ready=0 while reset is high. Storage is not reset; unwritten bytes read X.
- Pipeline: LAT stages. A request is accepted at edge E and produces a response with resp_valid=1 at edge E+LAT. There is one response per accepted request, stores included, and order is preserved.
- Backpressure: stall = resp_valid && !resp_ready. While stalled, all stages hold and req_ready=0. Otherwise req_ready=1. Full throughput is 1 request/cycle.
- Legality, evaluated at accept:
  - error if req_addr mod 2^size != 0;
  - error if req_addr + 2^size > MEM_BYTES (computed without ADDR_W overflow);
  - error if 2^size > DATA_W/8.
- Error response: resp_err=1, resp_rdata=0, no storage write. err_count increments at accept and saturates at 16'hFFFF.
- Store: bytes written at the accept edge. Bytes outside [addr, addr+2^size) are unchanged.
- Load: storage is sampled at the accept edge. A load accepted the cycle after a store to the same bytes returns the new data. Result bytes >= 2^size are zero.
- resp_rdata and resp_err are valid only while resp_valid=1. Both hold stable while stalled.
- Reset mid-operation: in-flight requests are discarded, no responses are issued, and stores already accepted remain in storage.

Optional Feature:
Macro DATAMEM_SIGNEXT_EN.
- Defined: a load with req_signed=1 sign-extends bit 8*2^size-1 through DATA_W-1. With req_signed=0 the load zero-extends.
- Undefined: req_signed is ignored and all loads zero-extend.

Test Plan:
- Reset then idle: resp_valid=0, err_count=0. Once reset deasserts, req_ready=1.
- Store addr 16, size 3, wdata 64'h8877665544332211, then load addr 16, size 0 -> rdata 64'h11. Load addr 18, size 1 -> rdata 64'h4433. Load addr 16, size 3 -> full value. Each response arrives LAT cycles after accept.
- Misaligned load addr 6, size 2 and out-of-range store addr 1020, size 3 -> resp_err=1, rdata=0, err_count=2. A following load at 1016 shows no bytes changed.
- Back-to-back 4 loads with resp_ready held 0 for 3 cycles -> req_ready=0 during the stall, responses stay stable, then drain in order with no loss or duplication.
- With DATAMEM_SIGNEXT_EN: store byte 8'h80 at addr 5, load addr 5, size 0, req_signed=1 -> 64'hFFFFFFFFFFFFFF80. With req_signed=0 -> 64'h80.
- Reset asserted with 2 loads in flight (LAT=2) -> no responses appear after reset, and stored data is preserved.
